// File: rtl/hazard_forward_ctl_pkg.sv
// Shared types and constants for the hazard/forwarding controller:
// forward-select codes, the shadow-stage record and the operand-select helper.
package hazard_forward_ctl_pkg;

    localparam int REG_BITS = 3;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_EM   = 2'b10;

    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] rd;
        logic                regWrite;
        logic                memRead;
    } shadow_t;

    // The nearer producer is checked first so the youngest result wins.
    function automatic logic [1:0] fwd_sel(
        input logic                used,
        input logic [REG_BITS-1:0] src,
        input shadow_t             near,
        input shadow_t             far
    );
        logic [1:0] sel;
        if (used && near.valid && near.regWrite && (near.rd == src)) begin
            sel = FWD_EM;
        end else if (used && far.valid && far.regWrite && (far.rd == src)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_NONE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline stage: hold has priority over clear-to-bubble,
// synchronous active-low reset clears every field.
module hazard_stage_reg
    import hazard_forward_ctl_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    hold_i,
    input  logic    clear_i,
    input  shadow_t d_i,
    output shadow_t q_o
);

    shadow_t stage_q;

    // Stage register with reset, hold and bubble insertion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else if (hold_i) begin
            stage_q <= stage_q;
        end else if (clear_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= d_i;
        end
    end

    assign q_o = stage_q;

endmodule

// File: rtl/hazard_forward_ctl.sv
// Hazard detection and EX forwarding-select generation for the 5-stage core.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_forward_ctl
    import hazard_forward_ctl_pkg::*;
#(
    parameter int REG_BITS = 3,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rs,
    input  logic [REG_BITS-1:0] id_rt,
    input  logic                id_rs_used,
    input  logic                id_rt_used,
    input  logic [REG_BITS-1:0] id_rd,
    input  logic                id_regWrite,
    input  logic                id_memRead,
    input  logic                ex_flush,
    input  logic                pipe_stall,
    output logic [1:0]          forward_a,
    output logic [1:0]          forward_b,
    output logic                stall,
    output logic [CNT_W-1:0]    perf_stall_cnt,
    output logic [CNT_W-1:0]    perf_fwd_cnt
);

    shadow_t    id_shadow_s;
    shadow_t    idex_q;
    shadow_t    exmem_q;
    shadow_t    memwb_q;
    logic       stall_s;
    logic       bubble_s;
    logic [1:0] fwd_a_d;
    logic [1:0] fwd_b_d;
    logic [1:0] fwd_a_q;
    logic [1:0] fwd_b_q;
    logic       unused_s;

    assign id_shadow_s = '{valid: id_valid, rd: id_rd, regWrite: id_regWrite, memRead: id_memRead};

    // Load-use detection against the instruction currently in EX; a flush or reset masks it.
    always_comb begin
        stall_s = 1'b0;
        if (rst_n && !ex_flush && id_valid && idex_q.valid && idex_q.memRead && idex_q.regWrite) begin
            stall_s = (id_rs_used && (id_rs == idex_q.rd)) || (id_rt_used && (id_rt == idex_q.rd));
        end else begin
            stall_s = 1'b0;
        end
    end

    assign bubble_s = stall_s | ex_flush;

    // Next forward selects: IDEX becomes EX/MEM and EXMEM becomes MEM/WB at the edge.
    always_comb begin
        fwd_a_d = FWD_NONE;
        fwd_b_d = FWD_NONE;
        if (bubble_s) begin
            fwd_a_d = FWD_NONE;
            fwd_b_d = FWD_NONE;
        end else begin
            fwd_a_d = fwd_sel(id_rs_used, id_rs, idex_q, exmem_q);
            fwd_b_d = fwd_sel(id_rt_used, id_rt, idex_q, exmem_q);
        end
    end

    // Forward-select registers load alongside IDEX.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd_a_q <= FWD_NONE;
            fwd_b_q <= FWD_NONE;
        end else if (pipe_stall) begin
            fwd_a_q <= fwd_a_q;
            fwd_b_q <= fwd_b_q;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    hazard_stage_reg u_idex (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold_i  (pipe_stall),
        .clear_i (bubble_s),
        .d_i     (id_shadow_s),
        .q_o     (idex_q)
    );

    hazard_stage_reg u_exmem (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold_i  (pipe_stall),
        .clear_i (1'b0),
        .d_i     (idex_q),
        .q_o     (exmem_q)
    );

    hazard_stage_reg u_memwb (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold_i  (pipe_stall),
        .clear_i (1'b0),
        .d_i     (exmem_q),
        .q_o     (memwb_q)
    );

    // MEMWB only retires metadata; WB-to-ID bypass is handled inside the register file.
    assign unused_s = ^{memwb_q, exmem_q.memRead};

    assign forward_a = fwd_a_q;
    assign forward_b = fwd_b_q;
    assign stall     = stall_s;

`ifdef HAZARD_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] fwd_cnt_d;
    logic [CNT_W-1:0] fwd_cnt_q;

    // Saturating counters advance only on non-frozen edges.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (!pipe_stall && stall_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (!pipe_stall && ((fwd_a_d != FWD_NONE) || (fwd_b_d != FWD_NONE)) && (fwd_cnt_q != CNT_MAX)) begin
            fwd_cnt_d = fwd_cnt_q + CNT_ONE;
        end else begin
            fwd_cnt_d = fwd_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            fwd_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_fwd_cnt   = fwd_cnt_q;
`else
    assign perf_stall_cnt = {CNT_W{1'b0}};
    assign perf_fwd_cnt   = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_forward_ctl.sv
// Self-checking bench for hazard_forward_ctl: directed scenarios with literal
// expectations plus randomized traffic checked against an instruction-level model.
module tb_hazard_forward_ctl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [2:0]  id_rs, id_rt, id_rd;
    logic        id_rs_used, id_rt_used, id_regWrite, id_memRead;
    logic        ex_flush, pipe_stall;
    logic [1:0]  forward_a, forward_b;
    logic        stall;
    logic [15:0] perf_stall_cnt, perf_fwd_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_forward_ctl #(.REG_BITS(3), .CNT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rs_used     (id_rs_used),
        .id_rt_used     (id_rt_used),
        .id_rd          (id_rd),
        .id_regWrite    (id_regWrite),
        .id_memRead     (id_memRead),
        .ex_flush       (ex_flush),
        .pipe_stall     (pipe_stall),
        .forward_a      (forward_a),
        .forward_b      (forward_b),
        .stall          (stall),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_fwd_cnt   (perf_fwd_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level model: the instructions now in EX and MEM, oldest last.
    typedef struct packed { bit v; bit [2:0] rd; bit wr; bit ld; } ins_t;
    ins_t m_ex  = '0;
    ins_t m_mem = '0;
    bit [1:0] m_fa = 2'b00;
    bit [1:0] m_fb = 2'b00;
    int m_cs = 0;
    int m_cf = 0;

    function automatic bit m_stall();
        if (!rst_n || ex_flush || !id_valid) return 1'b0;
        if (!(m_ex.v && m_ex.ld && m_ex.wr)) return 1'b0;
        return (id_rs_used && id_rs == m_ex.rd) || (id_rt_used && id_rt == m_ex.rd);
    endfunction

    // Distance 1 (EX) producer gives code 2, distance 2 (MEM) gives code 1.
    function automatic bit [1:0] m_fwd(input bit used, input bit [2:0] src);
        ins_t older [2];
        older[0] = m_ex;
        older[1] = m_mem;
        if (!used) return 2'b00;
        for (int d = 0; d < 2; d++) begin
            if (older[d].v && older[d].wr && older[d].rd == src) return 2'(2 - d);
        end
        return 2'b00;
    endfunction

    always @(posedge clk) begin
        bit s, b;
        bit [1:0] nfa, nfb;
        if (!rst_n) begin
            m_ex = '0; m_mem = '0; m_fa = 2'b00; m_fb = 2'b00; m_cs = 0; m_cf = 0;
        end else if (!pipe_stall) begin
            s   = m_stall();
            b   = s || ex_flush;
            nfa = b ? 2'b00 : m_fwd(id_rs_used, id_rs);
            nfb = b ? 2'b00 : m_fwd(id_rt_used, id_rt);
            if (s && m_cs < 65535) m_cs++;
            if ((nfa != 2'b00 || nfb != 2'b00) && m_cf < 65535) m_cf++;
            m_mem = m_ex;
            m_ex  = b ? ins_t'('0) : ins_t'({id_valid, id_rd, id_regWrite, id_memRead});
            m_fa  = nfa;
            m_fb  = nfb;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        chk("stall", stall, m_stall());
        chk("forward_a", forward_a, m_fa);
        chk("forward_b", forward_b, m_fb);
`ifdef HAZARD_PERF_EN
        chk("perf_stall_cnt", perf_stall_cnt, m_cs);
        chk("perf_fwd_cnt", perf_fwd_cnt, m_cf);
`else
        chk("perf_stall_cnt", perf_stall_cnt, 32'd0);
        chk("perf_fwd_cnt", perf_fwd_cnt, 32'd0);
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit v, input bit [2:0] rs, input bit rsu, input bit [2:0] rt,
                       input bit rtu, input bit [2:0] rd, input bit wr, input bit ld);
        id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
        id_rd = rd; id_regWrite = wr; id_memRead = ld;
    endtask

    initial begin
        int cs0;
        rst_n = 1'b0; ex_flush = 1'b0; pipe_stall = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        step(); step();
        chk("reset_fa", forward_a, 32'd0);
        chk("reset_fb", forward_b, 32'd0);
        chk("reset_stall", stall, 32'd0);
        chk("reset_cnt", perf_stall_cnt | perf_fwd_cnt, 32'd0);
        rst_n = 1'b1;

        // Back-to-back dependency.
        drv(1, 0, 0, 0, 0, 3, 1, 0); step();
        drv(1, 3, 1, 0, 0, 6, 0, 0); #1 chk("b2b_stall", stall, 32'd0); step();
        chk("b2b_fa", forward_a, 32'd2);

        // Distance-2 dependency on rt.
        drv(1, 0, 0, 0, 0, 5, 1, 0); step();
        drv(1, 0, 0, 0, 0, 7, 1, 0); step();
        drv(1, 0, 0, 5, 1, 6, 0, 0); step();
        chk("dist2_fb", forward_b, 32'd1);
        chk("dist2_fa", forward_a, 32'd0);

        // Youngest producer wins.
        drv(1, 0, 0, 0, 0, 2, 1, 0); step();
        drv(1, 0, 0, 0, 0, 2, 1, 0); step();
        drv(1, 2, 1, 0, 0, 6, 0, 0); step();
        chk("youngest_fa", forward_a, 32'd2);

        // Load-use: one bubble, then MEM/WB forward.
        cs0 = m_cs;
        drv(1, 0, 0, 0, 0, 4, 1, 1); step();
        drv(1, 4, 1, 0, 0, 6, 0, 0); #1 chk("lu_stall", stall, 32'd1); step();
        chk("lu_bubble_fa", forward_a, 32'd0);
        chk("lu_retry_stall", stall, 32'd0);
        step();
        chk("lu_fa", forward_a, 32'd1);
`ifdef HAZARD_PERF_EN
        chk("lu_perf", perf_stall_cnt, cs0 + 1);
`endif

        // Flush coinciding with load-use.
        drv(1, 0, 0, 0, 0, 1, 1, 1); step();
        drv(1, 1, 1, 1, 1, 6, 1, 0); ex_flush = 1'b1; #1 chk("flush_stall", stall, 32'd0); step();
        ex_flush = 1'b0;
        chk("flush_fa", forward_a, 32'd0);
        chk("flush_fb", forward_b, 32'd0);
        #1 chk("flush_idex_invalid", stall, 32'd0);
        step();

        // Global stall freezes everything but stall stays visible.
        drv(1, 0, 0, 0, 0, 4, 1, 0); step();
        drv(1, 4, 1, 0, 0, 4, 1, 1); step();
        drv(1, 4, 1, 0, 0, 6, 0, 0); pipe_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("pstall_stall", stall, 32'd1);
            step();
            chk("pstall_fa", forward_a, 32'd2);
            chk("pstall_fb", forward_b, 32'd0);
        end
        pipe_stall = 1'b0;
        step(); step();

        // Reset mid-stream discards EXMEM rd=1.
        drv(1, 0, 0, 0, 0, 1, 1, 0); step();
        drv(0, 0, 0, 0, 0, 0, 0, 0); step();
        rst_n = 1'b0; drv(1, 1, 1, 0, 0, 6, 0, 0); step();
        chk("rst_mid_fa", forward_a, 32'd0);
        chk("rst_mid_fb", forward_b, 32'd0);
        rst_n = 1'b1; step();
        chk("rst_reader_fa", forward_a, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst_n      = ($urandom_range(0, 99) != 0);
            pipe_stall = ($urandom_range(0, 9) == 0);
            ex_flush   = ($urandom_range(0, 11) == 0);
            drv($urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                3'($urandom_range(0, 7)), $urandom_range(0, 1) != 0, 3'($urandom_range(0, 7)),
                $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            step();
        end
        pipe_stall = 1'b0; ex_flush = 1'b0; rst_n = 1'b1;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
